alu_regfile_sequencer: RTL and testbench
========================================

Name: alu_regfile_sequencer

Overview:
- Program sequencer that sits directly upstream of alu_regfile and drives all of its control inputs.
- Holds a small loadable program memory and steps a PC through a FETCH/EXEC/WB state machine, one instruction per 3 cycles.
- Drives rd0_addr, rd1_addr, wr_addr, wr_data, wr_en, instr_i, alu_src1, alu_src2 and alu_op.
- Consumes result, ovf and take_branch for register write-back and conditional branching.

Parameters:
- ADDR_W, 4, program-memory address width; depth is 2**ADDR_W words.
- IW, 24, instruction word width; fixed field map below, other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  ADDR_W  program write address.
- prog_data  in  IW  program write data.
- start  in  1  run request, level-sampled each cycle.
- rd0_addr  out  2  to alu_regfile.
- rd1_addr  out  2  to alu_regfile.
- wr_addr  out  2  to alu_regfile.
- wr_data  out  9  to alu_regfile.
- wr_en  out  1  to alu_regfile.
- instr_i  out  8  immediate to alu_regfile.
- alu_src1  out  1  to alu_regfile.
- alu_src2  out  1  to alu_regfile.
- alu_op  out  3  to alu_regfile.
- result  in  8  from alu_regfile.
- ovf  in  1  from alu_regfile.
- take_branch  in  1  from alu_regfile.
- pc  out  ADDR_W  current PC.
- busy  out  1  high in FETCH/EXEC/WB.
- done  out  1  high in HALT.
- last_result  out  8  result captured in the most recent EXEC.
- last_ovf  out  1  ovf captured in the most recent EXEC.
- retired  out  8  count of retired instructions; wraps 255->0.

Behaviour:
- Instruction field map:
  - [23] halt, [22] br, [21] wb, [20:18] alu_op, [17] alu_src1, [16] alu_src2.
  - [15:14] rd0, [13:12] rd1, [11:10] wr_addr, [9:8] reserved (ignored), [7:0] imm.
- Reset (rst=0, asynchronous): state=IDLE, pc=0, IR=0, all outputs 0, retired=0, last_result=0, last_ovf=0. Program memory contents are not reset.
- Program memory: synchronous write on prog_we, honoured only in IDLE or HALT; ignored silently while busy. Read is registered.
- IDLE: on start=1, pc<=0, retired<=0, go to FETCH.
- FETCH (1 cycle): IR <= mem[pc].
- EXEC (1 cycle):
  - Control outputs driven combinationally from IR: alu_op, alu_src1, alu_src2, rd0_addr, rd1_addr, wr_addr, instr_i=imm.
  - At the end of the cycle, capture result->last_result, ovf->last_ovf, and take_branch into tb_q.
- WB (1 cycle):
  - Control outputs still held from IR.
  - wr_en = IR.wb, asserted for exactly this one cycle.
  - wr_data = {1'b0, last_result}.
  - retired increments at the end of WB.
  - Next PC: imm[ADDR_W-1:0] if (br && tb_q), else pc+1, wrapping from 2**ADDR_W-1 to 0.
  - If halt=1: go to HALT with pc unchanged. Write-back still occurs; branch is ignored.
  - Otherwise go to FETCH.
- HALT: done=1. start=1 restarts exactly as from IDLE (pc<=0, retired<=0, FETCH).
- start is ignored while busy.
- Outside EXEC/WB, all control outputs and wr_en are 0, wr_data=0.
- busy and done are never high together.
- Reset asserted mid-instruction aborts immediately. No partial write completes after rst falls, since wr_en drops asynchronously.

Test Plan:
- Reset/idle: hold rst=0 then release, no start -> all outputs 0, state IDLE, wr_en never asserts over 20 cycles.
- Load and run 2-instruction program:
  - mem[0]=0x2_1_0_0AA style word with wb=1, wr_addr=1, imm=0xAA, alu_op=3'b010; mem[1] has halt=1.
  - Stub drives result=0x5A.
  - Expect wr_en pulse at cycle 3 with wr_addr=1, wr_data=0x05A, instr_i=0xAA, alu_op=2.
  - Expect done=1 after cycle 6 and retired=2.
- Branch taken/not taken: mem[0] br=1, imm=5.
  - Stub take_branch=1 -> next fetch at pc=5.
  - Repeat with take_branch=0 -> next fetch at pc=1.
- PC wrap: ADDR_W=4, program with no halt and no branch, run 17 instructions -> pc sequence 0..15,0; retired=17.
- Load while busy: prog_we to addr 2 during EXEC -> mem[2] unchanged, verified by a later run. Same write during HALT -> takes effect.
- Reset mid-WB: rst=0 during a WB with wb=1 -> wr_en=0 immediately; after release, IDLE with pc=0 and retired=0.

Source files
------------

// File: rtl/alu_regfile_sequencer.sv
// alu_regfile_sequencer: program memory and FETCH/EXEC/WB sequencer driving alu_regfile
module alu_regfile_sequencer #(
  parameter int ADDR_W = 4,
  parameter int IW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [IW-1:0]     prog_data,
  input  logic              start,
  output logic [1:0]        rd0_addr,
  output logic [1:0]        rd1_addr,
  output logic [1:0]        wr_addr,
  output logic [8:0]        wr_data,
  output logic              wr_en,
  output logic [7:0]        instr_i,
  output logic              alu_src1,
  output logic              alu_src2,
  output logic [2:0]        alu_op,
  input  logic [7:0]        result,
  input  logic              ovf,
  input  logic              take_branch,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [7:0]        last_result,
  output logic              last_ovf,
  output logic [7:0]        retired
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic tb_q, tb_d;
  logic [7:0] last_result_q, last_result_d;
  logic last_ovf_q, last_ovf_d;
  logic [7:0] retired_q, retired_d;
  logic [IW-1:0] mem [2**ADDR_W];
  logic act, rsvd_unused;
  assign act = (state_q == EXEC) || (state_q == WB);
  assign rsvd_unused = ^ir_q[9:8];
  // program memory accepts writes only while the sequencer is parked
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE || state_q == HALT)) mem[prog_addr] <= prog_data;
  end
  // sequencer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      tb_q          <= 1'b0;
      last_result_q <= '0;
      last_ovf_q    <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      tb_q          <= tb_d;
      last_result_q <= last_result_d;
      last_ovf_q    <= last_ovf_d;
      retired_q     <= retired_d;
    end
  end
  // next-state: fetch, capture ALU result, then retire and pick the next pc
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    tb_d          = tb_q;
    last_result_d = last_result_q;
    last_ovf_d    = last_ovf_q;
    retired_d     = retired_q;
    case (state_q)
      IDLE, HALT: if (start) begin
        pc_d      = '0;
        retired_d = '0;
        state_d   = FETCH;
      end
      FETCH: begin
        ir_d    = mem[pc_q];
        state_d = EXEC;
      end
      EXEC: begin
        last_result_d = result;
        last_ovf_d    = ovf;
        tb_d          = take_branch;
        state_d       = WB;
      end
      WB: begin
        retired_d = retired_q + 8'd1;
        state_d   = ir_q[23] ? HALT : FETCH;
        pc_d      = ir_q[23] ? pc_q : (ir_q[22] && tb_q) ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign alu_op      = act ? ir_q[20:18] : '0;
  assign alu_src1    = act & ir_q[17];
  assign alu_src2    = act & ir_q[16];
  assign rd0_addr    = act ? ir_q[15:14] : '0;
  assign rd1_addr    = act ? ir_q[13:12] : '0;
  assign wr_addr     = act ? ir_q[11:10] : '0;
  assign instr_i     = act ? ir_q[7:0] : '0;
  assign wr_en       = (state_q == WB) & ir_q[21];
  assign wr_data     = (state_q == WB) ? {1'b0, last_result_q} : '0;
  assign pc          = pc_q;
  assign busy        = (state_q == FETCH) || act;
  assign done        = state_q == HALT;
  assign last_result = last_result_q;
  assign last_ovf    = last_ovf_q;
  assign retired     = retired_q;
endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// tb_alu_regfile_sequencer: scoreboard bench checking each write-back and run status
module tb_alu_regfile_sequencer;
  logic clk = 1'b0, rst = 1'b0, prog_we = 1'b0, start = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [23:0] prog_data = '0;
  logic [1:0] rd0_addr, rd1_addr, wr_addr;
  logic [8:0] wr_data;
  logic wr_en, alu_src1, alu_src2, busy, done, last_ovf;
  logic [7:0] instr_i, last_result, retired;
  logic [2:0] alu_op;
  logic [3:0] pc;
  logic [7:0] res_stub = '0;
  logic ovf_stub = 1'b0, tb_stub = 1'b0;
  int tests = 0, fails = 0;
  logic [31:0] q[$];
  logic [23:0] w0, w1, w2, w5, wn;

  alu_regfile_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .instr_i(instr_i), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_op(alu_op), .result(res_stub), .ovf(ovf_stub),
    .take_branch(tb_stub), .pc(pc), .busy(busy), .done(done), .last_result(last_result),
    .last_ovf(last_ovf), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic h, b, w, input logic [2:0] op, input logic s1, s2,
                                     input logic [1:0] r0, r1, wa, input logic [7:0] imm);
    return {h, b, w, op, s1, s2, r0, r1, wa, 2'b00, imm};
  endfunction

  function automatic logic [31:0] rec(input logic [3:0] p, input logic [23:0] w, input logic [7:0] r);
    return {p, w[11:10], 1'b0, r, w[7:0], w[20:18], w[17], w[16], w[15:14], w[13:12]};
  endfunction

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [23:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check("done", {31'b0, done}, 32'd1);
    check("busy_in_halt", {31'b0, busy}, 32'd0);
  endtask

  // monitor: every write-back strobe must match the oldest expected record
  always @(negedge clk) begin
    if (rst && wr_en) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got pc=%0d wr_addr=%0d wr_data=%h", pc, wr_addr, wr_data);
      end else begin
        logic [31:0] e, g;
        e = q.pop_front();
        g = {pc, wr_addr, wr_data, instr_i, alu_op, alu_src1, alu_src2, rd0_addr, rd1_addr};
        if (g !== e) begin
          fails++;
          $display("FAIL wb_record: got %h expected %h", g, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctrl", {3'b0, rd0_addr, rd1_addr, wr_addr, wr_data, wr_en, instr_i, alu_src1, alu_src2, alu_op}, 32'd0);
    check("rst_stat", {9'b0, pc, busy, done, last_result, last_ovf, retired}, 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_ctrl", {3'b0, rd0_addr, rd1_addr, wr_addr, wr_data, wr_en, instr_i, alu_src1, alu_src2, alu_op}, 32'd0);
    check("idle_stat", {9'b0, pc, busy, done, last_result, last_ovf, retired}, 32'd0);

    w0 = mk(0, 0, 1, 3'd2, 0, 0, 2'd0, 2'd0, 2'd1, 8'hAA) | 24'h000300;
    w1 = mk(1, 0, 0, 3'd0, 0, 0, 2'd0, 2'd0, 2'd0, 8'h00);
    load(0, w0); load(1, w1);
    res_stub = 8'h5A; ovf_stub = 1'b1;
    q.push_back({4'd0, 2'd1, 9'h05A, 8'hAA, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0});
    pulse_start();
    wait_done(20);
    check("run1_retired", {24'b0, retired}, 32'd2);
    check("run1_last_result", {24'b0, last_result}, 32'h5A);
    check("run1_last_ovf", {31'b0, last_ovf}, 32'd1);
    check("run1_pc", {28'b0, pc}, 32'd1);

    w0 = mk(0, 1, 1, 3'd5, 1, 0, 2'd2, 2'd3, 2'd2, 8'h05);
    w1 = mk(1, 0, 1, 3'd1, 0, 1, 2'd1, 2'd0, 2'd3, 8'h11);
    w5 = mk(1, 1, 1, 3'd4, 0, 0, 2'd3, 2'd3, 2'd0, 8'h0E);
    load(0, w0); load(1, w1); load(5, w5);
    res_stub = 8'h33; ovf_stub = 1'b0; tb_stub = 1'b1;
    q.push_back(rec(4'd0, w0, 8'h33)); q.push_back(rec(4'd5, w5, 8'h33));
    pulse_start();
    wait_done(30);
    check("br_taken_pc", {28'b0, pc}, 32'd5);
    check("br_taken_retired", {24'b0, retired}, 32'd2);
    check("br_taken_ovf", {31'b0, last_ovf}, 32'd0);
    tb_stub = 1'b0; res_stub = 8'hC4;
    q.push_back(rec(4'd0, w0, 8'hC4)); q.push_back(rec(4'd1, w1, 8'hC4));
    pulse_start();
    wait_done(30);
    check("br_not_taken_pc", {28'b0, pc}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      load(a, mk(0, 0, 1, a[2:0], a[0], a[1], a[3:2], a[1:0], a[1:0], {4'h9, a}));
    end
    tb_stub = 1'b1; res_stub = 8'h7E;
    for (int i = 0; i < 17; i++) begin
      logic [3:0] a;
      a = 4'(i);
      q.push_back({a, a[1:0], 9'h07E, {4'h9, a}, a[2:0], a[0], a[1], a[3:2], a[1:0]});
    end
    pulse_start();
    begin
      int n = 0;
      while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    end
    check("wrap_sb_drained", q.size(), 32'd0);
    @(posedge clk); #1;
    check("wrap_retired", {24'b0, retired}, 32'd17);
    check("wrap_pc", {28'b0, pc}, 32'd1);
    rst = 1'b0;
    #1;
    check("wrap_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b1;

    w0 = mk(0, 0, 1, 3'd1, 0, 0, 2'd0, 2'd1, 2'd1, 8'h01);
    w1 = mk(0, 0, 1, 3'd2, 1, 0, 2'd1, 2'd2, 2'd2, 8'h02);
    w2 = mk(1, 0, 1, 3'd3, 0, 1, 2'd2, 2'd3, 2'd3, 8'h03);
    wn = mk(1, 0, 1, 3'd7, 1, 1, 2'd1, 2'd1, 2'd0, 8'h77);
    load(0, w0); load(1, w1); load(2, w2);
    res_stub = 8'h19; tb_stub = 1'b0;
    q.push_back(rec(4'd0, w0, 8'h19)); q.push_back(rec(4'd1, w1, 8'h19)); q.push_back(rec(4'd2, w2, 8'h19));
    pulse_start();
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = wn;
    @(negedge clk); prog_we = 1'b0;
    wait_done(40);
    load(2, wn);
    q.push_back(rec(4'd0, w0, 8'h19)); q.push_back(rec(4'd1, w1, 8'h19)); q.push_back(rec(4'd2, wn, 8'h19));
    pulse_start();
    wait_done(40);
    check("halt_load_retired", {24'b0, retired}, 32'd3);

    q.push_back(rec(4'd0, w0, 8'h19));
    pulse_start();
    begin
      int n = 0;
      while (!wr_en && n < 20) begin @(negedge clk); n++; end
    end
    check("mid_wb_seen", {31'b0, wr_en}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_wb_wr_en", {31'b0, wr_en}, 32'd0);
    check("mid_wb_stat", {9'b0, pc, busy, done, last_result, last_ovf, retired}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    check("after_rst_idle", {9'b0, pc, busy, done, last_result, last_ovf, retired}, 32'd0);
    check("sb_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
